// File: rtl/mskaes_128bits_round_fsm.sv
// Control FSM sequencing ten masked AES-128 rounds through an external round module.
// Optional zero-flush CLEAN phase: define MSKAES_ROUND_FSM_CLEANING_EN.
module mskaes_128bits_round_fsm #(
  parameter int d       = 2,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [128*d-1:0] sh_plaintext,
  input  logic [128*d-1:0] sh_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [128*d-1:0] sh_ciphertext,
  output logic [128*d-1:0] sh_state_to_round,
  output logic [128*d-1:0] sh_key_to_round,
  output logic [8*d-1:0]   sh_RCON,
  output logic             cleaning_on,
  input  logic [128*d-1:0] sh_state_from_round,
  input  logic [128*d-1:0] sh_key_from_round,
  input  logic [128*d-1:0] sh_state_SR_from_round,
  input  logic [128*d-1:0] sh_state_AK_from_round,
  output logic             busy
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE,
    CLEAN
  } state_t;

  state_t state, state_nxt;

  logic [128*d-1:0] state_reg;
  logic [128*d-1:0] key_reg;
  logic [7:0]       rcon;
  logic [7:0]       rcon_nxt;
  logic [3:0]       round_cnt;
  logic [CW-1:0]    cyc_cnt;
  logic             load;
  logic             capture;
  logic             clear;
  logic             cyc_wrap;
  logic             last;

  assign cyc_wrap = (cyc_cnt == CYC_LAST);
  assign last     = (round_cnt == 4'd10);
  assign rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  assign sh_state_to_round = state_reg;
  assign sh_key_to_round   = key_reg;

  // Constant sharing of rcon: share 0 carries the value, other shares zero.
  always_comb begin
    sh_RCON = '0;
    for (int i = 0; i < 8; i++) begin
      sh_RCON[i*d] = rcon[i];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, handshake outputs and datapath strobes.
  always_comb begin
    state_nxt     = state;
    load          = 1'b0;
    capture       = 1'b0;
    clear         = 1'b0;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    cleaning_on   = 1'b0;
    busy          = 1'b1;
    sh_ciphertext = '0;
    unique case (state)
      IDLE: begin
        busy     = 1'b0;
        in_ready = ~rst;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        if (cyc_wrap) begin
          capture = 1'b1;
          if (last) state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid     = 1'b1;
        sh_ciphertext = sh_state_AK_from_round;
        if (out_ready) begin
          clear = 1'b1;
`ifdef MSKAES_ROUND_FSM_CLEANING_EN
          state_nxt = CLEAN;
`else
          state_nxt = IDLE;
`endif
        end
      end
      CLEAN: begin
`ifdef MSKAES_ROUND_FSM_CLEANING_EN
        cleaning_on = 1'b1;
        if (cyc_wrap) state_nxt = IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Round datapath: load, per-round capture, post-output wipe, cycle count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= '0;
      key_reg   <= '0;
      rcon      <= 8'h01;
      round_cnt <= 4'd0;
      cyc_cnt   <= '0;
    end else if (load) begin
      state_reg <= sh_plaintext;
      key_reg   <= sh_key;
      rcon      <= 8'h01;
      round_cnt <= 4'd1;
      cyc_cnt   <= '0;
    end else if (capture) begin
      cyc_cnt   <= '0;
      key_reg   <= sh_key_from_round;
      rcon      <= rcon_nxt;
      round_cnt <= round_cnt + 4'd1;
      state_reg <= last ? sh_state_SR_from_round
                        : sh_state_from_round;
    end else if (clear) begin
      state_reg <= '0;
      key_reg   <= '0;
      round_cnt <= 4'd0;
      cyc_cnt   <= '0;
    end else if (state == ROUND || state == CLEAN) begin
      cyc_cnt <= cyc_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_mskaes_128bits_round_fsm.sv
// Bench for mskaes_128bits_round_fsm with a behavioural masked AES round model.
// Covers FIPS-197 vector, hold, rcon probe, mid-run reset, cleaning, back-to-back.
module tb_mskaes_128bits_round_fsm;
  localparam int D   = 2;
  localparam int LAT = 4;

  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [128*D-1:0] sh_plaintext;
  logic [128*D-1:0] sh_key;
  logic             out_valid;
  logic             out_ready;
  logic [128*D-1:0] sh_ciphertext;
  logic [128*D-1:0] sh_state_to_round;
  logic [128*D-1:0] sh_key_to_round;
  logic [8*D-1:0]   sh_RCON;
  logic             cleaning_on;
  logic [128*D-1:0] sh_state_from_round;
  logic [128*D-1:0] sh_key_from_round;
  logic [128*D-1:0] sh_state_SR_from_round;
  logic [128*D-1:0] sh_state_AK_from_round;
  logic             busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mskaes_128bits_round_fsm #(.d(D), .LATENCY(LAT)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .sh_plaintext           (sh_plaintext),
    .sh_key                 (sh_key),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .sh_ciphertext          (sh_ciphertext),
    .sh_state_to_round      (sh_state_to_round),
    .sh_key_to_round        (sh_key_to_round),
    .sh_RCON                (sh_RCON),
    .cleaning_on            (cleaning_on),
    .sh_state_from_round    (sh_state_from_round),
    .sh_key_from_round      (sh_key_from_round),
    .sh_state_SR_from_round (sh_state_SR_from_round),
    .sh_state_AK_from_round (sh_state_AK_from_round),
    .busy                   (busy)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, t;
    r = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ t;
      t = xt(t);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, p;
    r = 8'h01;
    p = x;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^
           {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int n);
    return s[127-8*n -: 8];
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) begin
      o[127-8*n -: 8] = sbox(gb(s, 4*(((n/4) + (n%4)) % 4) + (n%4)));
    end
    return o;
  endfunction

  function automatic logic [127:0] mixcol(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(s, 4*c);
      a1 = gb(s, 4*c+1);
      a2 = gb(s, 4*c+2);
      a3 = gb(s, 4*c+3);
      o[127-32*c    -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[127-32*c-8  -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[127-32*c-16 -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[127-32*c-24 -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    t = t ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] p, input logic [127:0] k);
    logic [127:0] s, kk;
    logic [7:0]   rc;
    s  = p ^ k;
    kk = k;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      s = sub_shift(s);
      if (r < 10) s = mixcol(s);
      kk = key_next(kk, rc);
      s  = s ^ kk;
      rc = xt(rc);
    end
    return s;
  endfunction

  function automatic logic [128*D-1:0] share(input logic [127:0] x);
    logic [128*D-1:0] o;
    logic             b;
    o = '0;
    for (int i = 0; i < 128; i++) begin
      b = x[i];
      for (int j = 1; j < D; j++) begin
        o[i*D+j] = 1'($urandom);
        b = b ^ o[i*D+j];
      end
      o[i*D] = b;
    end
    return o;
  endfunction

  function automatic logic [127:0] unshare(input logic [128*D-1:0] v);
    logic [127:0] x;
    x = '0;
    for (int i = 0; i < 128; i++)
      for (int j = 0; j < D; j++) x[i] = x[i] ^ v[i*D+j];
    return x;
  endfunction

  function automatic logic [7:0] rshare(input logic [8*D-1:0] v, input int j);
    logic [7:0] x;
    for (int i = 0; i < 8; i++) x[i] = v[i*D+j];
    return x;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Round-module model: unmask, compute, re-mask, LAT-1 register delay.
  logic [127:0]     u_s, u_k;
  logic [7:0]       u_rc;
  logic [128*D-1:0] p_s  [LAT-1];
  logic [128*D-1:0] p_sr [LAT-1];
  logic [128*D-1:0] p_k  [LAT-1];

  assign u_s  = unshare(sh_state_to_round);
  assign u_k  = unshare(sh_key_to_round);
  assign u_rc = rshare(sh_RCON, 0) ^ rshare(sh_RCON, 1);

  always @(posedge clk) begin
    p_sr[0] <= share(sub_shift(u_s ^ u_k));
    p_s[0]  <= share(mixcol(sub_shift(u_s ^ u_k)));
    p_k[0]  <= share(key_next(u_k, u_rc));
    for (int i = 1; i < LAT-1; i++) begin
      p_sr[i] <= p_sr[i-1];
      p_s[i]  <= p_s[i-1];
      p_k[i]  <= p_k[i-1];
    end
  end

  assign sh_state_SR_from_round = p_sr[LAT-2];
  assign sh_state_from_round    = p_s[LAT-2];
  assign sh_key_from_round      = p_k[LAT-2];
  assign sh_state_AK_from_round = sh_state_to_round ^ sh_key_to_round;

  task automatic load(input logic [127:0] p, input logic [127:0] k);
    int w;
    w = 0;
    @(negedge clk);
    sh_plaintext = share(p);
    sh_key       = share(k);
    in_valid     = 1'b1;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_chk++;
    if (w >= 200) $display("FAIL load_accept: in_ready never seen within %0d cycles", w);
    else n_pass++;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 600) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    sh_plaintext = '0;
    sh_key       = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({in_ready, busy, out_valid, cleaning_on} !== 4'b0000)
      $display("FAIL reset_flags: got rdy/busy/ov/cl=%b want 0000",
               {in_ready, busy, out_valid, cleaning_on});
    else n_pass++;
    n_chk++;
    if (sh_state_to_round !== '0 || sh_key_to_round !== '0)
      $display("FAIL reset_regs: state=%h key=%h want 0", sh_state_to_round, sh_key_to_round);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready);
    else n_pass++;
    n_chk++;
    if (rshare(sh_RCON, 0) !== 8'h01 || rshare(sh_RCON, 1) !== 8'h00 || sh_ciphertext !== '0)
      $display("FAIL reset_rcon: rcon=%h ct=%h want 01/0", sh_RCON, sh_ciphertext);
    else n_pass++;
  endtask

  task automatic test_fips_hold_clean();
    int cnt;
    logic [128*D-1:0] ct0;
    logic exp_cl, exp_rdy;
    load(FP, FK);
    n_chk++;
    if (busy !== 1'b1) $display("FAIL fips_busy: got %b want 1", busy);
    else n_pass++;
    wait_done(cnt);
    n_chk++;
    if (cnt != 10*LAT) $display("FAIL fips_latency: got %0d want %0d", cnt, 10*LAT);
    else n_pass++;
    n_chk++;
    if (unshare(sh_ciphertext) !== FC)
      $display("FAIL fips_ct: got %h want %h", unshare(sh_ciphertext), FC);
    else n_pass++;
    ct0          = sh_ciphertext;
    sh_plaintext = share(rnd128());
    sh_key       = share(rnd128());
    in_valid     = 1'b1;
    for (int i = 0; i < 7; i++) begin
      n_chk++;
      if (out_valid !== 1'b1 || sh_ciphertext !== ct0 || in_ready !== 1'b0)
        $display("FAIL hold_c%0d: ov=%b rdy=%b ct=%h want ov=1 rdy=0 ct=%h",
                 i, out_valid, in_ready, sh_ciphertext, ct0);
      else n_pass++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    handshake();
    for (int i = 1; i <= LAT+1; i++) begin
`ifdef MSKAES_ROUND_FSM_CLEANING_EN
      exp_cl  = (i <= LAT);
      exp_rdy = (i == LAT+1);
`else
      exp_cl  = 1'b0;
      exp_rdy = 1'b1;
`endif
      n_chk++;
      if (cleaning_on !== exp_cl || in_ready !== exp_rdy || out_valid !== 1'b0)
        $display("FAIL clean_c%0d: cl=%b rdy=%b ov=%b want cl=%b rdy=%b ov=0",
                 i, cleaning_on, in_ready, out_valid, exp_cl, exp_rdy);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_rcon();
    int rc;
    int k;
    logic [127:0] p, key;
    p   = rnd128();
    key = rnd128();
    wait_idle();
    load(p, key);
    rc = 1;
    k  = 0;
    for (int cnt = 0; cnt < 10*LAT; cnt++) begin
      if (cnt % LAT == LAT-1) begin
        n_chk++;
        if (rshare(sh_RCON, 0) !== 8'(rc) || rshare(sh_RCON, 1) !== 8'h00)
          $display("FAIL rcon_r%0d: s0=%h s1=%h want %h/00",
                   k, rshare(sh_RCON, 0), rshare(sh_RCON, 1), 8'(rc));
        else n_pass++;
        rc = rc * 2;
        if (rc > 255) rc = rc ^ 'h11b;
        k++;
      end
      @(negedge clk);
    end
    n_chk++;
    if (out_valid !== 1'b1 || unshare(sh_ciphertext) !== aes_enc(p, key))
      $display("FAIL rcon_ct: ov=%b got %h want %h",
               out_valid, unshare(sh_ciphertext), aes_enc(p, key));
    else n_pass++;
    handshake();
  endtask

  task automatic test_reset_mid();
    int cnt;
    wait_idle();
    load(FP, FK);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || sh_state_to_round !== '0 ||
        sh_key_to_round !== '0 || rshare(sh_RCON, 0) !== 8'h01)
      $display("FAIL midrst_state: ov=%b busy=%b st=%h key=%h rc=%h",
               out_valid, busy, sh_state_to_round, sh_key_to_round, sh_RCON);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    load(FP, FK);
    wait_done(cnt);
    n_chk++;
    if (cnt != 10*LAT || unshare(sh_ciphertext) !== FC)
      $display("FAIL midrst_rerun: lat=%0d ct=%h want %0d %h",
               cnt, unshare(sh_ciphertext), 10*LAT, FC);
    else n_pass++;
    handshake();
  endtask

  task automatic test_back_to_back();
    logic [127:0] pa, ka, pb, kb;
    int cnt, w, exp_w;
    logic early;
    pa = rnd128(); ka = rnd128();
    pb = rnd128(); kb = rnd128();
    wait_idle();
    @(negedge clk);
    sh_plaintext = share(pa);
    sh_key       = share(ka);
    in_valid     = 1'b1;
    @(negedge clk);
    sh_plaintext = share(pb);
    sh_key       = share(kb);
    cnt   = 0;
    early = 1'b0;
    while (!out_valid && cnt < 600) begin
      if (in_ready) early = 1'b1;
      @(negedge clk);
      cnt++;
    end
    n_chk++;
    if (cnt != 10*LAT || early || unshare(sh_ciphertext) !== aes_enc(pa, ka))
      $display("FAIL b2b_first: lat=%0d early=%b ct=%h want %0d 0 %h",
               cnt, early, unshare(sh_ciphertext), 10*LAT, aes_enc(pa, ka));
    else n_pass++;
    handshake();
    w = 1;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
`ifdef MSKAES_ROUND_FSM_CLEANING_EN
    exp_w = LAT + 1;
`else
    exp_w = 1;
`endif
    n_chk++;
    if (w != exp_w) $display("FAIL b2b_gap: ready at cycle %0d want %0d", w, exp_w);
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(cnt);
    n_chk++;
    if (cnt != 10*LAT || unshare(sh_ciphertext) !== aes_enc(pb, kb))
      $display("FAIL b2b_second: lat=%0d ct=%h want %0d %h",
               cnt, unshare(sh_ciphertext), 10*LAT, aes_enc(pb, kb));
    else n_pass++;
    handshake();
  endtask

  task automatic test_random();
    logic [127:0] p, k;
    int cnt;
    for (int t = 0; t < 3; t++) begin
      p = rnd128();
      k = rnd128();
      wait_idle();
      load(p, k);
      wait_done(cnt);
      n_chk++;
      if (cnt != 10*LAT || unshare(sh_ciphertext) !== aes_enc(p, k))
        $display("FAIL rand_t%0d: lat=%0d ct=%h want %0d %h",
                 t, cnt, unshare(sh_ciphertext), 10*LAT, aes_enc(p, k));
      else n_pass++;
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_fips_hold_clean();
    test_rcon();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
